alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational ALU: add, sub, multiply, divide on unsigned operands.
//  Results are registered. Add/sub complete in 1 cycle; mul/div are iterative and take `width` cycles.
//  Valid/ready on input and output. Overflow and divide-by-zero are reported.
//  Sits between operand source and result sink; one operation in flight at a time.
// PARAMETERS
//  width   6   operand width in bits (>=2); result is 2*width bits
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands/func valid
//  in_ready   out  1        block can accept an operation
//  a          in   width    operand A (unsigned)
//  b          in   width    operand B (unsigned)
//  func       in   2        00 add, 01 sub, 10 mul, 11 div
//  out_valid  out  1        result valid, held until accepted
//  out_ready  in   1        sink accepts result
//  out        out  2*width  result
//  ovf        out  1        add carry / sub borrow / div-by-zero; 0 for mul
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=0 during reset, 1 from first edge after release.
//   out_valid=0, out=0, ovf=0; counter and internal regs cleared.
//  Reset mid-operation aborts the operation; no result is ever presented for it.
//  States:
//   IDLE: in_ready=1. On in_valid: latch a,b,func.
//    add/sub -> DONE. mul/div -> BUSY with cnt=0.
//   BUSY: in_ready=0; one iteration per cycle; cnt increments; when cnt==width-1 -> DONE.
//   DONE: out_valid=1; out/ovf stable. On out_ready -> IDLE, out_valid drops next cycle.
//  Inputs in BUSY/DONE are ignored; in_valid need not be dropped.
//  Latency (accept edge = N): add/sub out_valid from N+1; mul/div out_valid from N+width+1.
//   Throughput: 1 op per (latency+1) cycles with out_ready tied 1.
//  add: out = {width'0, (a+b) mod 2^width}; ovf = carry out.
//  sub: out = {width'0, (a-b) mod 2^width}; ovf = (a<b).
//  mul: shift-add, one partial-product bit per cycle; out = a*b (exact, 2*width bits); ovf=0.
//  div: restoring, one quotient bit per cycle; out = {q, r}, q=a/b, r=a%b; ovf=0.
//   b==0: no iteration error. Still takes width cycles; out = {all ones, a}; ovf=1.
//  out/ovf change only on transition into DONE; they hold their last values in IDLE/BUSY,
//   but are meaningful only while out_valid=1.
//  out_ready while out_valid=0 has no effect.
// TESTING (width=6)
//  add a=40,b=30, out_ready=1 -> out_valid at N+1, out=12'h006, ovf=1; in_ready back next cycle.
//  sub a=5,b=9 -> out=12'h03C, ovf=1. sub a=9,b=5 -> out=12'h004, ovf=0.
//  mul a=63,b=63 -> out_valid at N+7, out=12'hF81, ovf=0. mul a=0,b=17 -> out=0.
//  div a=45,b=7 -> out_valid at N+7, out=12'h183 (q=6, r=3), ovf=0.
//   div a=13,b=0 -> out=12'hFCD, ovf=1.
//  Backpressure: mul with out_ready=0 for 3 cycles after out_valid -> out/out_valid stable;
//   new in_valid ignored until out_ready=1.
//  Reset: assert rst_n=0 at cnt=3 of a div -> all outputs 0 immediately; after release,
//   IDLE with in_ready=1; no stale out_valid.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide, one operation in flight, results registered on entry to DONE.
module alu_seq #(
  parameter int width = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  input  logic [1:0]           func,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   out,
  output logic                 ovf,
  output logic [1:0]           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on state; out_valid is held with out/ovf stable until out_ready.

  localparam int CW = $clog2(width);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic                 rst_done;
  logic [width-1:0]     a_reg;
  logic [width-1:0]     b_reg;
  logic                 op_div;
  logic [CW-1:0]        cnt;
  logic [2*width-1:0]   acc;
  logic [width-1:0]     rem;
  logic [width-1:0]     quo;

  logic                 accept;
  logic                 last;
  logic [width:0]       add_res;
  logic [width:0]       sub_res;
  logic [2*width-1:0]   mul_add;
  logic [2*width-1:0]   acc_next;
  logic [width:0]       div_shift;
  logic [width:0]       div_diff;
  logic                 div_ge;
  logic [width-1:0]     rem_next;
  logic [width-1:0]     quo_next;

  assign in_ready  = rst_done && (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign accept    = in_ready && in_valid;
  assign last      = (cnt == CW'(width - 1));

  assign add_res = {1'b0, a} + {1'b0, b};
  assign sub_res = {1'b0, a} - {1'b0, b};

  // Multiply: add the multiplicand shifted by the current bit position of b.
  assign mul_add  = b_reg[cnt] ? ({{width{1'b0}}, a_reg} << cnt) : '0;
  assign acc_next = acc + mul_add;

  // Divide: bring down the next dividend bit; the sign of the trial difference
  // decides the quotient bit, since the partial remainder is always below b.
  assign div_shift = {rem, quo[width-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_ge    = ~div_diff[width];
  assign rem_next  = div_ge ? div_diff[width-1:0] : div_shift[width-1:0];
  assign quo_next  = {quo[width-2:0], div_ge};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = func[1] ? BUSY : DONE;
      BUSY: if (last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rst_done <= 1'b0;
    end else begin
      state    <= state_next;
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_div <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      out    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= a;
            b_reg  <= b;
            op_div <= func[0];
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= a;
            if (!func[1]) begin
              out <= {{width{1'b0}}, func[0] ? sub_res[width-1:0] : add_res[width-1:0]};
              ovf <= func[0] ? sub_res[width] : add_res[width];
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          acc <= acc_next;
          rem <= rem_next;
          quo <= quo_next;
          if (last) begin
            if (!op_div) begin
              out <= acc_next;
              ovf <= 1'b0;
            end else if (b_reg == '0) begin
              out <= {{width{1'b1}}, a_reg};
              ovf <= 1'b1;
            end else begin
              out <= {quo_next, rem_next};
              ovf <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model with a latency-tracked expected queue,
// directed literal cases, backpressure, mid-operation reset and randomized traffic.
module tb_alu_seq;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     func = '0;
  logic           in_ready;
  logic           out_valid;
  logic           ovf;
  logic [2*W-1:0] out;
  logic [1:0]     dbg_state;

  alu_seq #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rst_seen = 1'b0;
  bit pending = 1'b0;
  int ready_at = 0;
  logic [2*W-1:0] exp_q[$];
  bit exp_ovf_q[$];

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: result and flag straight from the arithmetic definition.
  function automatic logic [2*W:0] model(int av, int bv, logic [1:0] f);
    int r;
    int o;
    r = 0;
    o = 0;
    case (f)
      2'b00: begin r = (av + bv) % 64; o = (av + bv >= 64) ? 1 : 0; end
      2'b01: begin r = (av - bv + 64) % 64; o = (av < bv) ? 1 : 0; end
      2'b10: begin r = av * bv; o = 0; end
      default: begin
        if (bv == 0) begin r = 63 * 64 + av; o = 1; end
        else begin r = (av / bv) * 64 + (av % bv); o = 0; end
      end
    endcase
    return {o[0], r[2*W-1:0]};
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst_n;
  end

  // Compare process: every cycle, DUT outputs against the model's expectations.
  always @(negedge clk) begin
    bit exp_v;
    if (!rst_n) begin
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
    end else begin
      exp_v = pending && (cyc >= ready_at);
      chk("in_ready", in_ready, rst_seen && !pending);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
        chk("out", out, exp_q[0]);
        chk("ovf", ovf, exp_ovf_q[0]);
      end
    end
  end

  // Called at negedge+1: drive inputs for the next rising edge and advance the model.
  task automatic tick(bit iv, int av, int bv, logic [1:0] f, bit ordy);
    logic [2*W:0] m;
    in_valid  = iv;
    a         = av[W-1:0];
    b         = bv[W-1:0];
    func      = f;
    out_ready = ordy;
    if (rst_n && !pending && rst_seen && iv) begin
      m = model(av, bv, f);
      exp_q.push_back(m[2*W-1:0]);
      exp_ovf_q.push_back(m[2*W]);
      pending  = 1'b1;
      ready_at = cyc + 1 + (f[1] ? W : 0);
    end else if (rst_n && pending && cyc >= ready_at && ordy) begin
      void'(exp_q.pop_front());
      void'(exp_ovf_q.pop_front());
      pending = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(int hold);
    #1;
    rst_n     = 1'b0;
    pending   = 1'b0;
    rst_seen  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_ovf_q.delete();
    #1;
    chk("reset immediate out_valid", out_valid, 0);
    chk("reset immediate in_ready", in_ready, 0);
    chk("reset immediate out", out, 0);
    chk("reset immediate ovf", ovf, 0);
    repeat (hold) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic exec_op(string name, int av, int bv, logic [1:0] f,
                         logic [2*W-1:0] exp_out, bit exp_ovf, int exp_lat);
    int n;
    tick(1, av, bv, f, 1);
    n = 1;
    while (!out_valid && n < 20) begin
      tick(0, 0, 0, 2'b00, 1);
      n++;
    end
    chk({name, " latency"}, n, exp_lat);
    chk({name, " out"}, out, exp_out);
    chk({name, " ovf"}, ovf, exp_ovf);
    tick(0, 0, 0, 2'b00, 1);
  endtask

  initial begin
    int n;
    @(negedge clk);
    #1;
    do_reset(3);
    tick(0, 0, 0, 2'b00, 1);
    chk("post-reset in_ready", in_ready, 1);

    exec_op("add 40+30", 40, 30, 2'b00, 12'h006, 1, 1);
    chk("in_ready after add", in_ready, 1);
    exec_op("sub 5-9", 5, 9, 2'b01, 12'h03C, 1, 1);
    exec_op("sub 9-5", 9, 5, 2'b01, 12'h004, 0, 1);
    exec_op("mul 63*63", 63, 63, 2'b10, 12'hF81, 0, 7);
    exec_op("mul 0*17", 0, 17, 2'b10, 12'h000, 0, 7);
    exec_op("div 45/7", 45, 7, 2'b11, 12'h183, 0, 7);
    exec_op("div 13/0", 13, 0, 2'b11, 12'hFCD, 1, 7);

    // Backpressure: result held, new operations ignored until the sink accepts.
    tick(1, 10, 20, 2'b10, 0);
    n = 1;
    while (!out_valid && n < 20) begin
      tick(0, 0, 0, 2'b00, 0);
      n++;
    end
    chk("bp latency", n, 7);
    repeat (3) begin
      tick(1, $urandom_range(0, 63), $urandom_range(0, 63), 2'($urandom_range(0, 3)), 0);
      chk("bp held out", out, 12'h0C8);
      chk("bp held out_valid", out_valid, 1);
    end
    tick(1, 5, 6, 2'b00, 1);
    tick(1, 5, 6, 2'b00, 1);
    chk("bp next add out", out, 12'h00B);
    repeat (3) tick(0, 0, 0, 2'b00, 1);

    // Reset in the middle of a divide: nothing may ever be presented for it.
    tick(1, 45, 7, 2'b11, 1);
    repeat (3) tick(0, 0, 0, 2'b00, 1);
    do_reset(2);
    tick(0, 0, 0, 2'b00, 1);
    chk("mid-op reset in_ready", in_ready, 1);
    repeat (10) begin
      tick(0, 0, 0, 2'b00, 1);
      chk("mid-op reset no stale out_valid", out_valid, 0);
    end

    // Randomized traffic with random backpressure and occasional zero divisors.
    repeat (1500) begin
      tick($urandom_range(0, 1),
           $urandom_range(0, 63),
           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0);
    end
    repeat (12) tick(0, 0, 0, 2'b00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
